// File: rtl/hyperbus_txn_arbiter.sv
// Command scheduler for the single HyperBus PHY. It arbitrates requesters round-robin and splits transfers into CS-bounded chunks.
// Define HYPER_ARB_WDT_EN to enable the WAIT-state watchdog; when it is undefined, err_o is tied to 0.
module hyperbus_txn_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned LenWidth    = 16,
  parameter int unsigned MaxBurst    = 64,
  parameter int unsigned CsGapCycles = 4,
  parameter int unsigned WdtCycles   = 1024,
  localparam int unsigned IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*LenWidth-1:0]    req_len_i,
  input  logic [NumReq-1:0]             req_write_i,
  output logic [NumReq-1:0]             req_done_o,
  output logic                          phy_valid_o,
  input  logic                          phy_ready_i,
  output logic [AddrWidth-1:0]          phy_addr_o,
  output logic [LenWidth-1:0]           phy_len_o,
  output logic                          phy_write_o,
  output logic [IdW-1:0]                phy_id_o,
  input  logic                          phy_done_i,
  output logic                          busy_o,
  output logic [NumReq-1:0]             err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int unsigned GapW = (CsGapCycles > 1) ? $clog2(CsGapCycles) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((CsGapCycles > 0) ? CsGapCycles - 1 : 0);
  localparam logic [LenWidth:0] MaxChunk = (LenWidth + 1)'(MaxBurst);

  logic [1:0]           r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth:0]    r_rem;
  logic                 r_write;
  logic [IdW-1:0]       r_id;
  logic [IdW-1:0]       r_ptr;
  logic [GapW-1:0]      r_gap_cnt;
  logic [NumReq-1:0]    r_done;

  logic                 w_found;
  logic [IdW-1:0]       w_gnt_id;
  logic [IdW-1:0]       w_cand;
  logic [NumReq-1:0]    w_ready;
  logic                 w_accept;
  logic [AddrWidth-1:0] w_req_addr;
  logic [LenWidth-1:0]  w_req_len;
  logic [LenWidth:0]    w_chunk;
  logic [LenWidth-1:0]  w_chunk_m1;
  logic                 w_gap_done;
  logic                 w_chunk_end;
  logic [IdW-1:0]       w_ptr_next;
  logic                 w_wdt_fire;

  // Round-robin search starting at the pointer; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_cand   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_cand = IdW'((32'(r_ptr) + i) % NumReq);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_id = w_cand;
      end
    end
  end

  // Grant is withheld in the cycle a done pulse is being shown, giving the 1-cycle done->ready spacing.
  always_comb begin
    w_ready = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_ready[i] = (r_state == S_IDLE) && !(|r_done) && w_found && (w_gnt_id == IdW'(i));
    end
  end

  assign w_accept   = |w_ready;
  assign w_req_addr = req_addr_i[w_gnt_id*AddrWidth +: AddrWidth];
  assign w_req_len  = req_len_i[w_gnt_id*LenWidth +: LenWidth];

  assign w_chunk     = (r_rem > MaxChunk) ? MaxChunk : r_rem;
  assign w_chunk_m1  = LenWidth'(w_chunk - 1'b1);
  assign w_gap_done  = (r_state == S_GAP) && (r_gap_cnt == GapLast);
  assign w_chunk_end = w_gap_done ||
                       ((r_state == S_WAIT) && phy_done_i && (CsGapCycles == 0));
  assign w_ptr_next  = (r_id == IdW'(NumReq - 1)) ? '0 : r_id + 1'b1;

`ifdef HYPER_ARB_WDT_EN
  localparam int unsigned WdtW = (WdtCycles > 1) ? $clog2(WdtCycles) : 1;
  logic [WdtW-1:0] r_wdt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdt <= r_wdt + 1'b1;
    end else begin
      r_wdt <= '0;
    end
  end

  assign w_wdt_fire = (r_state == S_WAIT) && !phy_done_i && (r_wdt == WdtW'(WdtCycles - 1));

  always_comb begin
    err_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      err_o[i] = w_wdt_fire && (r_id == IdW'(i));
    end
  end
`else
  assign w_wdt_fire = 1'b0;
  assign err_o      = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_write   <= 1'b0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_gap_cnt <= '0;
      r_done    <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= w_req_addr & ~AddrWidth'(1);
            r_rem   <= {1'b0, w_req_len} + 1'b1;
            r_write <= req_write_i[w_gnt_id];
            r_id    <= w_gnt_id;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (phy_ready_i) begin
            r_addr  <= r_addr + AddrWidth'({w_chunk, 1'b0});
            r_rem   <= r_rem - w_chunk;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (phy_done_i && (CsGapCycles != 0)) begin
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
          end
        end
        default: begin
          if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
      endcase

      // Shared exit for GAP completion and the zero-gap shortcut straight from WAIT.
      if (w_chunk_end) begin
        if (r_rem != '0) begin
          r_state <= S_ISSUE;
        end else begin
          r_state      <= S_IDLE;
          r_done[r_id] <= 1'b1;
          r_ptr        <= w_ptr_next;
        end
      end else if (w_wdt_fire) begin
        r_state <= S_IDLE;
        r_rem   <= '0;
        r_ptr   <= w_ptr_next;
      end
    end
  end

  assign req_ready_o = w_ready;
  assign req_done_o  = r_done;
  assign phy_valid_o = (r_state == S_ISSUE);
  assign phy_addr_o  = r_addr;
  assign phy_len_o   = (r_state == S_ISSUE) ? w_chunk_m1 : '0;
  assign phy_write_o = r_write;
  assign phy_id_o    = r_id;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_hyperbus_txn_arbiter.sv
// Directed bench for hyperbus_txn_arbiter. Instance a uses MaxBurst=64 and a 4-cycle gap.
// Instance b uses MaxBurst=32 with no gap.
module tb_hyperbus_txn_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_ready, a_write, a_done, a_err;
  logic [63:0] a_addr;
  logic [31:0] a_len;
  logic        a_pvalid, a_pready, a_pwrite, a_pid, a_pdone, a_busy;
  logic [31:0] a_paddr;
  logic [15:0] a_plen;

  logic [1:0]  b_valid, b_ready, b_write, b_done, b_err;
  logic [63:0] b_addr;
  logic [31:0] b_len;
  logic        b_pvalid, b_pready, b_pwrite, b_pid, b_pdone, b_busy;
  logic [31:0] b_paddr;
  logic [15:0] b_plen;

  hyperbus_txn_arbiter #(.NumReq(2), .MaxBurst(64), .CsGapCycles(4)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_addr_i(a_addr),
    .req_len_i(a_len), .req_write_i(a_write), .req_done_o(a_done),
    .phy_valid_o(a_pvalid), .phy_ready_i(a_pready), .phy_addr_o(a_paddr),
    .phy_len_o(a_plen), .phy_write_o(a_pwrite), .phy_id_o(a_pid),
    .phy_done_i(a_pdone), .busy_o(a_busy), .err_o(a_err)
  );

  hyperbus_txn_arbiter #(.NumReq(2), .MaxBurst(32), .CsGapCycles(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_addr_i(b_addr),
    .req_len_i(b_len), .req_write_i(b_write), .req_done_o(b_done),
    .phy_valid_o(b_pvalid), .phy_ready_i(b_pready), .phy_addr_o(b_paddr),
    .phy_len_o(b_plen), .phy_write_o(b_pwrite), .phy_id_o(b_pid),
    .phy_done_i(b_pdone), .busy_o(b_busy), .err_o(b_err)
  );

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in ISSUE; finishes in the first cycle after the chunk's phy_done_i.
  task automatic issue_a(input string tag, input logic [31:0] ea, input logic [15:0] el,
                         input logic ew, input logic eid);
    check({tag, "_valid"}, 64'(a_pvalid), 64'd1);
    check({tag, "_addr"},  64'(a_paddr),  64'(ea));
    check({tag, "_len"},   64'(a_plen),   64'(el));
    check({tag, "_write"}, 64'(a_pwrite), 64'(ew));
    check({tag, "_id"},    64'(a_pid),    64'(eid));
    a_pready = 1'b1;
    tick();
    a_pready = 1'b0;
    check({tag, "_wait"}, 64'(a_pvalid), 64'd0);
    tick();
    tick();
    a_pdone = 1'b1;
    tick();
    a_pdone = 1'b0;
  endtask

  task automatic gap_a(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_nv"},    64'(a_pvalid), 64'd0);
      check({tag, "_nrdy"},  64'(a_ready),  64'd0);
      check({tag, "_ndone"}, 64'(a_done),   64'd0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] saw;
    int unsigned eid;
    a_valid = '0; a_addr = '0; a_len = '0; a_write = '0; a_pready = 0; a_pdone = 0;
    b_valid = '0; b_addr = '0; b_len = '0; b_write = '0; b_pready = 0; b_pdone = 0;
    repeat (3) tick();

    check("rst_a_ready",  64'(a_ready),  64'd0);
    check("rst_a_done",   64'(a_done),   64'd0);
    check("rst_a_pvalid", 64'(a_pvalid), 64'd0);
    check("rst_a_paddr",  64'(a_paddr),  64'd0);
    check("rst_a_plen",   64'(a_plen),   64'd0);
    check("rst_a_pwrite", 64'(a_pwrite), 64'd0);
    check("rst_a_pid",    64'(a_pid),    64'd0);
    check("rst_a_busy",   64'(a_busy),   64'd0);
    check("rst_a_err",    64'(a_err),    64'd0);
    check("rst_b_plen",   64'(b_plen),   64'd0);
    check("rst_b_busy",   64'(b_busy),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // T1: single 4-beat read from requester 0
    a_valid = 2'b01; a_addr[31:0] = 32'h100; a_len[15:0] = 16'd3; a_write = 2'b00;
    #1;
    check("t1_ready", 64'(a_ready), 64'b01);
    tick();
    a_valid = 2'b00;
    check("t1_busy", 64'(a_busy), 64'd1);
    issue_a("t1", 32'h100, 16'd3, 1'b0, 1'b0);
    gap_a("t1_gap", 4);
    check("t1_done", 64'(a_done), 64'b01);
    check("t1_idle", 64'(a_busy), 64'd0);
    tick();
    check("t1_done_clr", 64'(a_done), 64'd0);

    // T2: 150-beat write from requester 1, requester 0 waiting meanwhile
    a_valid = 2'b10; a_addr[63:32] = 32'h0; a_len[31:16] = 16'd149; a_write = 2'b10;
    #1;
    check("t2_ready", 64'(a_ready), 64'b10);
    tick();
    a_valid = 2'b01; a_addr[31:0] = 32'h200; a_len[15:0] = 16'd0;
    issue_a("t2c0", 32'h0, 16'd63, 1'b1, 1'b1);
    gap_a("t2g0", 4);
    issue_a("t2c1", 32'h80, 16'd63, 1'b1, 1'b1);
    gap_a("t2g1", 4);
    issue_a("t2c2", 32'h100, 16'd21, 1'b1, 1'b1);
    gap_a("t2g2", 4);
    check("t2_done", 64'(a_done), 64'b10);
    check("t2_rdy_hold", 64'(a_ready), 64'd0);
    tick();

    // T3: both requesters continuously valid with 1-beat transfers
    a_valid = 2'b11; a_addr[63:32] = 32'h300; a_len[31:16] = 16'd0;
    #1;
    for (int k = 0; k < 5; k++) begin
      eid = k % 2;
      check("t3_grant", 64'(a_ready), 64'(1 << eid));
      tick();
      issue_a("t3", (eid == 1) ? 32'h300 : 32'h200, 16'd0, eid[0], eid[0]);
      gap_a("t3_gap", 4);
      check("t3_done", 64'(a_done), 64'(1 << eid));
      tick();
    end
    a_valid = 2'b00;

    // T4: backpressure and address wrap on instance b
    b_valid = 2'b01; b_addr[31:0] = 32'hFFFF_FFC0; b_len[15:0] = 16'd63; b_write = 2'b00;
    #1;
    check("t4_ready", 64'(b_ready), 64'b01);
    tick();
    b_valid = 2'b00;
    for (int k = 0; k < 7; k++) begin
      check("t4_hold_v", 64'(b_pvalid), 64'd1);
      check("t4_hold_a", 64'(b_paddr),  64'hFFFF_FFC0);
      check("t4_hold_l", 64'(b_plen),   64'd31);
      tick();
    end
    b_pready = 1'b1;
    tick();
    b_pready = 1'b0;
    tick();
    b_pdone = 1'b1;
    tick();
    b_pdone = 1'b0;
    check("t4_c1_valid", 64'(b_pvalid), 64'd1);
    check("t4_c1_addr",  64'(b_paddr),  64'h0);
    check("t4_c1_len",   64'(b_plen),   64'd31);
    check("t4_c1_ndone", 64'(b_done),   64'd0);
    b_pready = 1'b1;
    tick();
    b_pready = 1'b0;
    b_pdone = 1'b1;
    tick();
    b_pdone = 1'b0;
    check("t4_done", 64'(b_done), 64'b01);
    check("t4_idle", 64'(b_busy), 64'd0);

    // T5: reset while requester 1 sits in WAIT
    a_valid = 2'b10; a_addr[63:32] = 32'h400; a_write = 2'b10;
    #1;
    check("t5_ready", 64'(a_ready), 64'b10);
    tick();
    a_valid = 2'b00;
    check("t5_issue", 64'(a_pvalid), 64'd1);
    a_pready = 1'b1;
    tick();
    a_pready = 1'b0;
    tick();
    check("t5_wait_busy", 64'(a_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy",  64'(a_busy),  64'd0);
    check("t5_rst_paddr", 64'(a_paddr), 64'd0);
    check("t5_rst_pid",   64'(a_pid),   64'd0);
    tick();
    check("t5_rst_pwrite", 64'(a_pwrite), 64'd0);
    check("t5_rst_pvalid", 64'(a_pvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw = saw | a_done;
    end
    check("t5_no_done", 64'(saw), 64'd0);
    a_valid = 2'b11; a_addr[31:0] = 32'h500;
    #1;
    check("t5_ptr0", 64'(a_ready), 64'b01);

    // T6: phy_done_i withheld; without the watchdog the FSM stays in WAIT
    tick();
    a_valid = 2'b00;
    a_pready = 1'b1;
    tick();
    a_pready = 1'b0;
    saw = '0;
    for (int k = 0; k < 40; k++) begin
      saw = saw | a_err;
      tick();
    end
    check("t6_no_err", 64'(saw),      64'd0);
    check("t6_busy",   64'(a_busy),   64'd1);
    check("t6_nvalid", 64'(a_pvalid), 64'd0);
    a_pdone = 1'b1;
    tick();
    a_pdone = 1'b0;
    gap_a("t6_gap", 4);
    check("t6_done", 64'(a_done), 64'b01);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
